deser_field: RTL and testbench

- Protobuf wire-format field deserializer, the receive-side counterpart of the aggregate serializer.
- Consumes a byte stream over a valid/ready handshake and decodes one field per record: tag varint, then a varint, fixed64, fixed32 or length prefix.
- Emits {field_id, wire_type, value} over a valid/ready output.
- For length-delimited fields (wire type 2) it emits the length only; a downstream aggregate handler consumes the payload bytes.

---
 rtl/deser_field.sv | 214 +++++++++++++++++++++
 tb/tb_deser_field.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deser_field.sv
// deser_field: protobuf wire-format field deserializer.
// Decodes one field per record from a byte stream (tag varint followed by a
// varint, fixed64, fixed32 or length prefix) and presents
// {field_id, wire_type, value} on a valid/ready output. For length-delimited
// fields only the length is emitted; the payload bytes belong to a downstream
// handler, so the next byte accepted here is parsed as a new tag.
// Optional build macro DESER_ZIGZAG_EN adds port zz_en, which selects sint64
// zigzag decoding of wire-type-0 values when it is high at the final tag byte.

module deser_field #(
    parameter int MAX_VARINT_BYTES = 10,
    parameter int FIELD_ID_W       = 29
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FIELD_ID_W-1:0] field_id,
    output logic [2:0]            wire_type,
    output logic [63:0]           value,
    output logic                  error,
    output logic                  busy
`ifdef DESER_ZIGZAG_EN
    ,
    input  logic                  zz_en
`endif
);

    typedef enum logic [2:0] {
        S_TAG    = 3'd0,
        S_VARINT = 3'd1,
        S_FIXED  = 3'd2,
        S_EMIT   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    // Index of the last permitted value-varint byte, and of the last tag byte.
    localparam logic [3:0] LAST_VBYTE = 4'(MAX_VARINT_BYTES - 1);
    localparam logic [3:0] LAST_TBYTE = 4'd4;

    state_t          state;
    logic [63:0]     acc;    // value being assembled for the current field
    logic [3:0]      cnt;    // bytes already accepted in the current phase
    logic            fix8;   // FIXED phase length: 1 = 8 bytes, 0 = 4 bytes
`ifdef DESER_ZIGZAG_EN
    logic            zz;     // zz_en captured at the terminating tag byte
`endif

    logic                  take;
    logic [6:0]            vshift;
    logic [71:0]           vwide;
    logic [63:0]           vacc;
    logic                  vovf;
    logic [31:0]           tag;
    logic [FIELD_ID_W-1:0] tag_id;
    logic [63:0]           facc;
    logic                  fix_last;
    logic [63:0]           vresult;

    // sint64 zigzag decode: 0,1,2,3 -> 0,-1,1,-2.
    function automatic logic [63:0] zigzag(input logic [63:0] raw);
        return (raw >> 1) ^ (64'd0 - {63'd0, raw[0]});
    endfunction

    // Input is only accepted while parsing; reset also forces it low.
    assign in_ready = reset && ((state == S_TAG) || (state == S_VARINT) || (state == S_FIXED));
    assign take     = in_valid && in_ready;
    assign busy     = (state != S_TAG) || (cnt != 4'd0);

    // Varint byte i contributes its 7 payload bits at bit 7*i. The extra
    // upper bits of vwide catch payload that would land above bit 63.
    assign vshift = 7'(cnt) * 7'd7;
    assign vwide  = {65'd0, in_byte[6:0]} << vshift;
    assign vacc   = acc | vwide[63:0];
    assign vovf   = |vwide[71:64];

    // Tag bits above 31 are dropped; field number is everything above the type.
    assign tag    = vacc[31:0];
    assign tag_id = FIELD_ID_W'(tag[31:3]);

    // Fixed-width values are little-endian: byte k lands at bits 8k+7:8k.
    assign facc     = acc | ({56'd0, in_byte} << {cnt[2:0], 3'b000});
    assign fix_last = (cnt[2:0] == (fix8 ? 3'd7 : 3'd3));

`ifdef DESER_ZIGZAG_EN
    assign vresult = (zz && (wire_type == 3'd0)) ? zigzag(vacc) : vacc;
`else
    assign vresult = vacc;
`endif

    // Field-parsing state machine; all outputs except in_ready/busy are registered.
    // NOTE: every assignment in this clocked block is non-blocking so each
    // register samples the pre-edge value of the others, as real flops do.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_TAG;
            acc       <= 64'd0;
            cnt       <= 4'd0;
            fix8      <= 1'b0;
            out_valid <= 1'b0;
            field_id  <= '0;
            wire_type <= 3'd0;
            value     <= 64'd0;
            error     <= 1'b0;
`ifdef DESER_ZIGZAG_EN
            zz        <= 1'b0;
`endif
        end else begin
            case (state)
                S_TAG: begin
                    if (take) begin
                        if (in_byte[7]) begin
                            // Continuation: a 5th byte that still continues is illegal.
                            if (cnt == LAST_TBYTE) begin
                                state <= S_ERROR;
                                error <= 1'b1;
                            end else begin
                                acc <= vacc;
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            field_id  <= tag_id;
                            wire_type <= tag[2:0];
                            acc       <= 64'd0;
                            cnt       <= 4'd0;
`ifdef DESER_ZIGZAG_EN
                            zz        <= zz_en;
`endif
                            if (tag_id == '0) begin
                                state <= S_ERROR;
                                error <= 1'b1;
                            end else begin
                                case (tag[2:0])
                                    3'd0, 3'd2: state <= S_VARINT;
                                    3'd1: begin
                                        state <= S_FIXED;
                                        fix8  <= 1'b1;
                                    end
                                    3'd5: begin
                                        state <= S_FIXED;
                                        fix8  <= 1'b0;
                                    end
                                    default: begin
                                        // Start/end group and reserved types.
                                        state <= S_ERROR;
                                        error <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                end

                S_VARINT: begin
                    if (take) begin
                        if ((cnt == LAST_VBYTE) && (in_byte[7] || vovf)) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else if (in_byte[7]) begin
                            acc <= vacc;
                            cnt <= cnt + 4'd1;
                        end else begin
                            value     <= vresult;
                            out_valid <= 1'b1;
                            state     <= S_EMIT;
                            acc       <= 64'd0;
                            cnt       <= 4'd0;
                        end
                    end
                end

                S_FIXED: begin
                    if (take) begin
                        if (fix_last) begin
                            value     <= facc;
                            out_valid <= 1'b1;
                            state     <= S_EMIT;
                            acc       <= 64'd0;
                            cnt       <= 4'd0;
                        end else begin
                            acc <= facc;
                            cnt <= cnt + 4'd1;
                        end
                    end
                end

                S_EMIT: begin
                    // Outputs hold until the consumer takes them.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_TAG;
                        acc       <= 64'd0;
                        cnt       <= 4'd0;
                    end
                end

                S_ERROR: begin
                    // Sticky until reset; nothing is consumed or emitted.
                    error     <= 1'b1;
                    out_valid <= 1'b0;
                end

                default: begin
                    state <= S_ERROR;
                    error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deser_field.sv
// Self-checking bench for deser_field. Fields are generated at random, encoded
// to wire format by the bench's own encoder, and the decoded outputs are
// compared with the original field contents held in an expectation queue.
// Directed cases cover latency, back-pressure, error entry and reset.

module tb_deser_field;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'd0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [28:0] field_id;
    logic [2:0]  wire_type;
    logic [63:0] value;
    logic        error;
    logic        busy;
`ifdef DESER_ZIGZAG_EN
    logic        zz_en = 1'b0;
`endif

    typedef struct {
        logic [28:0] fid;
        logic [2:0]  wt;
        logic [63:0] val;
    } rec_t;

    rec_t        exp_q[$];
    logic [7:0]  tx_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        ready_mode = 1'b0;  // 1 = consumer refuses every output

    always #5 clk = ~clk;

    deser_field #(.MAX_VARINT_BYTES(10), .FIELD_ID_W(29)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .field_id  (field_id),
        .wire_type (wire_type),
        .value     (value),
        .error     (error),
        .busy      (busy)
`ifdef DESER_ZIGZAG_EN
        ,
        .zz_en     (zz_en)
`endif
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Wire-format encoders (the inverse of what the DUT does).
    function automatic void push_varint(input logic [63:0] v);
        logic [63:0] x = v;
        while (x >= 64'h80) begin
            tx_q.push_back({1'b1, x[6:0]});
            x = x >> 7;
        end
        tx_q.push_back({1'b0, x[6:0]});
    endfunction

    function automatic void push_le(input logic [63:0] v, input int n);
        for (int k = 0; k < n; k++) tx_q.push_back(8'((v >> (8 * k)) & 64'hFF));
    endfunction

    function automatic logic [63:0] zz_encode(input logic [63:0] s);
        return (s << 1) ^ {64{s[63]}};
    endfunction

    // Queue one field's bytes and its expected decode.
    function automatic void push_field(input logic [28:0] fid, input logic [2:0] wt,
                                       input logic [63:0] val, input logic zz);
        rec_t r;
        push_varint({32'd0, fid, wt});
        r.fid = fid;
        r.wt  = wt;
        r.val = val;
        case (wt)
            3'd0:    push_varint(zz ? zz_encode(val) : val);
            3'd2:    push_varint(val);
            3'd1:    push_le(val, 8);
            default: begin
                push_le(val, 4);
                r.val = {32'd0, val[31:0]};
            end
        endcase
        exp_q.push_back(r);
    endfunction

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("accept", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
    endtask

    task automatic send_tx(input bit gaps);
        while (tx_q.size() > 0) begin
            send_byte(tx_q.pop_front());
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        tx_q.delete();
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fields", {field_id, wire_type, value}, 96'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Output consumer: compares each new output with the expectation queue,
    // checks hold-while-stalled and the drop after each handshake.
    initial begin
        logic        held = 1'b0;
        logic        prev_hs = 1'b0;
        logic [95:0] snap = '0;
        rec_t        cur;
        forever begin
            @(negedge clk);
            if (!reset) begin
                held      = 1'b0;
                prev_hs   = 1'b0;
                out_ready = 1'b0;
            end else begin
                if (prev_hs) begin
                    check("drop_valid", out_valid, 1'b0);
                    check("ready_back", in_ready, 1'b1);
                end
                prev_hs = 1'b0;
                if (out_valid) begin
                    if (!held) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_valid", out_valid, 1'b0);
                        end else begin
                            cur = exp_q.pop_front();
                            check("field_id", field_id, cur.fid);
                            check("wire_type", wire_type, cur.wt);
                            check("value", value, cur.val);
                        end
                        held = 1'b1;
                        snap = {field_id, wire_type, value};
                    end else begin
                        check("hold_stable", {field_id, wire_type, value}, snap);
                        check("hold_in_ready", in_ready, 1'b0);
                    end
                    out_ready = !ready_mode && ($urandom_range(0, 2) != 0);
                    if (out_ready) begin
                        prev_hs = 1'b1;
                        held    = 1'b0;
                    end
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        logic [28:0] fid;
        logic [2:0]  wt;
        logic [63:0] val;
        logic        zz;

        @(negedge clk);
        check("rst_state", {out_valid, in_ready, error, busy}, 4'b0000);
        check("rst_value", value, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", in_ready, 1'b1);

        // 08 96 01 -> id 1, varint 150, one-cycle latency.
        exp_q.push_back('{29'd1, 3'd0, 64'd150});
        send_byte(8'h08);
        send_byte(8'h96);
        check("lat_before", out_valid, 1'b0);
        send_byte(8'h01);
        check("lat_after", out_valid, 1'b1);
        wait_drain();

        // fixed64 and fixed32 little-endian.
        exp_q.push_back('{29'd2, 3'd1, 64'h0807060504030201});
        foreach (tx_q[i]) tx_q.delete(i);
        tx_q = '{8'h11, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_tx(1'b1);
        exp_q.push_back('{29'd5, 3'd5, 64'h12345678});
        tx_q = '{8'h2D, 8'h78, 8'h56, 8'h34, 8'h12};
        send_tx(1'b1);
        wait_drain();

        // Length-delimited 1A 03 held off by the consumer, then 08 01 as a new tag.
        ready_mode = 1'b1;
        exp_q.push_back('{29'd3, 3'd2, 64'd3});
        tx_q = '{8'h1A, 8'h03};
        send_tx(1'b0);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        ready_mode = 1'b0;
        exp_q.push_back('{29'd1, 3'd0, 64'd1});
        tx_q = '{8'h08, 8'h01};
        send_tx(1'b0);
        wait_drain();

        // Boundaries: zero length, 10-byte all-ones varint, largest field id.
        exp_q.push_back('{29'd3, 3'd2, 64'd0});
        tx_q = '{8'h1A, 8'h00};
        send_tx(1'b0);
        exp_q.push_back('{29'd1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF});
        tx_q = '{8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
        send_tx(1'b0);
        push_field(29'h1FFF_FFFF, 3'd0, 64'd7, 1'b0);
        send_tx(1'b0);
        wait_drain();

        // Random fields from the encoder model.
        for (int n = 0; n < 200; n++) begin
            fid = ($urandom_range(0, 1) == 1) ? 29'($urandom_range(1, 15))
                                              : 29'($urandom_range(1, 32'h1FFF_FFFF));
            case ($urandom_range(0, 3))
                0:       wt = 3'd0;
                1:       wt = 3'd1;
                2:       wt = 3'd2;
                default: wt = 3'd5;
            endcase
            val = {$urandom, $urandom} >> $urandom_range(0, 63);
            zz  = 1'b0;
`ifdef DESER_ZIGZAG_EN
            zz    = 1'($urandom_range(0, 1)) && (wt == 3'd0);
            zz_en = zz;
`endif
            push_field(fid, wt, val, zz);
            send_tx(1'b1);
        end
        wait_drain();

`ifdef DESER_ZIGZAG_EN
        zz_en = 1'b1;
        exp_q.push_back('{29'd1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFE});
        tx_q = '{8'h08, 8'h03};
        send_tx(1'b0);
        wait_drain();
        zz_en = 1'b0;
`endif

        // Reset mid-field discards the partial value.
        send_byte(8'h08);
        send_byte(8'h96);
        check("mid_busy", busy, 1'b1);
        do_reset();
        exp_q.push_back('{29'd1, 3'd0, 64'd1});
        tx_q = '{8'h08, 8'h01};
        send_tx(1'b0);
        wait_drain();

        // Group wire type -> sticky error, nothing further accepted.
        send_byte(8'h0B);
        check("grp_error", error, 1'b1);
        in_valid = 1'b1;
        in_byte  = 8'h08;
        repeat (4) @(negedge clk);
        check("grp_in_ready", in_ready, 1'b0);
        check("grp_sticky", {error, out_valid}, 2'b10);
        in_valid = 1'b0;
        do_reset();

        // Value varint overflowing on its 10th byte.
        send_byte(8'h08);
        for (int i = 0; i < 9; i++) send_byte(8'hFF);
        check("ovf_pre", error, 1'b0);
        send_byte(8'hFF);
        check("ovf_error", error, 1'b1);
        check("ovf_in_ready", in_ready, 1'b0);
        do_reset();

        // Field number zero.
        send_byte(8'h00);
        check("zero_id_error", error, 1'b1);
        do_reset();

        // Tag whose 5th byte still continues.
        tx_q = '{8'h88, 8'h80, 8'h80, 8'h80};
        send_tx(1'b0);
        check("tag5_pre", error, 1'b0);
        send_byte(8'h80);
        check("tag5_error", error, 1'b1);
        do_reset();

        check("post_reset_error", error, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
